// File: rtl/cmp_pkg.sv
// Shared comparator relation codes and the guesser state encoding.
package cmp_pkg;

  localparam logic [2:0] CMP_GT = 3'b100;
  localparam logic [2:0] CMP_EQ = 3'b010;
  localparam logic [2:0] CMP_LT = 3'b001;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    NEXT  = 3'd1,
    PROBE = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_t;

endpackage

// File: rtl/bsearch_guesser.sv
// Binary-search initiator: drives guess into a magnitude comparator and narrows lo/hi from its code.
// Optional macro GUESS_TIMEOUT_EN bounds the PROBE wait on comp_valid to TIMEOUT cycles.
module bsearch_guesser
  import cmp_pkg::*;
#(
  parameter int N       = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic [N-1:0]           guess,
  output logic                   guess_valid,
  input  logic [2:0]             comp,
  input  logic                   comp_valid,
  output logic                   done,
  output logic [N-1:0]           result,
  output logic [$clog2(N+2)-1:0] steps,
  output logic                   err
);

  localparam int SW = $clog2(N+2);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("bsearch_guesser: TIMEOUT must be at least 1");
  end

  state_t         r_state;
  logic [N-1:0]   r_lo, r_hi, r_guess, r_result;
  logic           r_gv, r_done, r_err;
  logic [SW-1:0]  r_steps;
  logic [N-1:0]   w_half, w_mid;

  // lo <= hi always holds, so the midpoint never exceeds hi and fits in N bits.
  assign w_half = (r_hi - r_lo) >> 1;
  assign w_mid  = r_lo + w_half;

`ifdef GUESS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT+1);
  logic [TW-1:0] r_tmo;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_lo     <= '0;
      r_hi     <= '0;
      r_guess  <= '0;
      r_result <= '0;
      r_gv     <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_steps  <= '0;
`ifdef GUESS_TIMEOUT_EN
      r_tmo    <= '0;
`endif
    end else begin
      case (r_state)
        IDLE, DONE, ERR: begin
          if (start) begin
            r_lo    <= '0;
            r_hi    <= '1;
            r_steps <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_state <= NEXT;
          end
        end
        NEXT: begin
          r_guess <= w_mid;
          r_gv    <= 1'b1;
          r_state <= PROBE;
`ifdef GUESS_TIMEOUT_EN
          r_tmo   <= '0;
`endif
        end
        PROBE: begin
          if (comp_valid) begin
            r_steps <= r_steps + 1'b1;
            r_gv    <= 1'b0;
            case (comp)
              CMP_EQ: begin
                r_result <= r_guess;
                r_done   <= 1'b1;
                r_state  <= DONE;
              end
              // Bounds are checked before the subtract/add so lo/hi never wrap.
              CMP_GT: begin
                if (r_guess == r_lo) begin
                  r_err   <= 1'b1;
                  r_state <= ERR;
                end else begin
                  r_hi    <= r_guess - 1'b1;
                  r_state <= NEXT;
                end
              end
              CMP_LT: begin
                if (r_guess == r_hi) begin
                  r_err   <= 1'b1;
                  r_state <= ERR;
                end else begin
                  r_lo    <= r_guess + 1'b1;
                  r_state <= NEXT;
                end
              end
              default: begin
                r_err   <= 1'b1;
                r_state <= ERR;
              end
            endcase
          end
`ifdef GUESS_TIMEOUT_EN
          else if (r_tmo == TW'(TIMEOUT-1)) begin
            r_gv    <= 1'b0;
            r_err   <= 1'b1;
            r_state <= ERR;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign guess       = r_guess;
  assign guess_valid = r_gv;
  assign done        = r_done;
  assign result      = r_result;
  assign steps       = r_steps;
  assign err         = r_err;

endmodule

// File: tb/tb_bsearch_guesser.sv
// Bench for bsearch_guesser (N=4): table of searches with a guess scoreboard, plus reset/timeout sequences.
module tb_bsearch_guesser;
  localparam int N = 4;
  localparam int SW = $clog2(N+2);

  logic           clk = 1'b0;
  logic           rst, start, comp_valid;
  logic [2:0]     comp;
  logic [N-1:0]   guess, result;
  logic           guess_valid, done, err;
  logic [SW-1:0]  steps;

  logic [N-1:0]   secret;
  int             mode;   // 0 good comparator, 1 stuck 100, 2 stuck 111

  int n_checks = 0;
  int n_err    = 0;
  int exp_q[$];

  bsearch_guesser #(.N(N), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .start(start),
    .guess(guess), .guess_valid(guess_valid),
    .comp(comp), .comp_valid(comp_valid),
    .done(done), .result(result), .steps(steps), .err(err)
  );

  always #5 clk = ~clk;

  // Comparator model, secret on y.
  always_comb begin
    comp = 3'b000;
    case (mode)
      1:       comp = 3'b100;
      2:       comp = 3'b111;
      default: comp = (guess > secret) ? 3'b100 : (guess == secret) ? 3'b010 : 3'b001;
    endcase
  end

  typedef struct packed {
    logic [N-1:0]        secret;
    logic [1:0]          mode;
    logic [2:0]          stall;
    logic                poke;
    logic [2:0]          ng;
    logic [4:0][N-1:0]   g;
    logic [N-1:0]        res;
    logic [2:0]          stp;
    logic                dn;
    logic                er;
    logic [5:0]          cyc;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input vec_t v, input int idx);
    int cyc, pidx, stall_cnt;
    logic [N-1:0] held;
    for (int i = 0; i < int'(v.ng); i++) exp_q.push_back(int'(v.g[i]));
    secret     = v.secret;
    mode       = int'(v.mode);
    comp_valid = (v.stall == 0);
    start      = 1'b1;
    step();
    start = 1'b0;
    check($sformatf("v%0d steps_clear", idx), int'(steps), 0);
    check($sformatf("v%0d done_clear", idx), int'(done), 0);
    check($sformatf("v%0d err_clear", idx), int'(err), 0);
    cyc = 1; pidx = 0; stall_cnt = 0; held = '0;
    while (!(done || err) && cyc < 200) begin
      start = 1'b0;
      if (guess_valid) begin
        if (stall_cnt == 0) held = guess;
        else check($sformatf("v%0d guess_hold", idx), int'(guess), int'(held));
        comp_valid = (stall_cnt >= int'(v.stall));
        if (v.poke && pidx == 1) start = 1'b1;
        if (comp_valid) begin
          if (exp_q.size() == 0) check($sformatf("v%0d extra_probe", idx), int'(guess), -1);
          else check($sformatf("v%0d guess%0d", idx, pidx), int'(guess), exp_q.pop_front());
          pidx++;
          stall_cnt = 0;
        end else stall_cnt++;
      end
      step();
      cyc++;
    end
    start = 1'b0;
    if (cyc >= 200) check($sformatf("v%0d search_timeout", idx), cyc, -1);
    check($sformatf("v%0d end_cycle", idx), cyc, int'(v.cyc));
    check($sformatf("v%0d done", idx), int'(done), int'(v.dn));
    check($sformatf("v%0d err", idx), int'(err), int'(v.er));
    check($sformatf("v%0d steps", idx), int'(steps), int'(v.stp));
    if (v.dn) check($sformatf("v%0d result", idx), int'(result), int'(v.res));
    check($sformatf("v%0d missing_probes", idx), exp_q.size(), 0);
    exp_q.delete();
    // Outputs hold while idle in DONE/ERR.
    step(); step();
    check($sformatf("v%0d hold_done", idx), int'(done), int'(v.dn));
    check($sformatf("v%0d hold_err", idx), int'(err), int'(v.er));
    check($sformatf("v%0d hold_gv", idx), int'(guess_valid), 0);
  endtask

  initial begin
    //        secret mode stall poke ng  guesses (g[4]..g[0])       res stp dn er cyc
    tbl[0] = '{4'd9,  2'd0, 3'd0, 1'b0, 3'd3, {4'd0,4'd0,4'd9,4'd11,4'd7},  4'd9, 3'd3, 1'b1, 1'b0, 6'd7};
    tbl[1] = '{4'd15, 2'd0, 3'd0, 1'b0, 3'd5, {4'd15,4'd14,4'd13,4'd11,4'd7}, 4'd15, 3'd5, 1'b1, 1'b0, 6'd11};
    tbl[2] = '{4'd0,  2'd0, 3'd0, 1'b0, 3'd4, {4'd0,4'd0,4'd1,4'd3,4'd7},   4'd0, 3'd4, 1'b1, 1'b0, 6'd9};
    tbl[3] = '{4'd5,  2'd0, 3'd0, 1'b0, 3'd3, {4'd0,4'd0,4'd5,4'd3,4'd7},   4'd5, 3'd3, 1'b1, 1'b0, 6'd7};
    tbl[4] = '{4'd9,  2'd1, 3'd0, 1'b0, 3'd4, {4'd0,4'd0,4'd1,4'd3,4'd7},   4'd0, 3'd4, 1'b0, 1'b1, 6'd9};
    tbl[5] = '{4'd9,  2'd2, 3'd0, 1'b0, 3'd1, {4'd0,4'd0,4'd0,4'd0,4'd7},   4'd0, 3'd1, 1'b0, 1'b1, 6'd3};
    tbl[6] = '{4'd9,  2'd0, 3'd3, 1'b0, 3'd3, {4'd0,4'd0,4'd9,4'd11,4'd7},  4'd9, 3'd3, 1'b1, 1'b0, 6'd16};
    tbl[7] = '{4'd9,  2'd0, 3'd0, 1'b1, 3'd3, {4'd0,4'd0,4'd9,4'd11,4'd7},  4'd9, 3'd3, 1'b1, 1'b0, 6'd7};

    rst = 1'b1; start = 1'b0; comp_valid = 1'b1; secret = '0; mode = 0;
    step(); step();
    rst = 1'b0;
    check("rst guess", int'(guess), 0);
    check("rst guess_valid", int'(guess_valid), 0);
    check("rst done", int'(done), 0);
    check("rst result", int'(result), 0);
    check("rst steps", int'(steps), 0);
    check("rst err", int'(err), 0);

    for (int i = 0; i < 8; i++) run(tbl[i], i);

    // Reset during the second probe aborts the search.
    secret = 4'd9; mode = 0; comp_valid = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    step(); step(); step();
    check("midrst gv_before", int'(guess_valid), 1);
    check("midrst guess_before", int'(guess), 11);
    rst = 1'b1; step(); rst = 1'b0;
    check("midrst guess", int'(guess), 0);
    check("midrst guess_valid", int'(guess_valid), 0);
    check("midrst done", int'(done), 0);
    check("midrst result", int'(result), 0);
    check("midrst steps", int'(steps), 0);
    check("midrst err", int'(err), 0);
    step(); step();
    check("midrst idle_gv", int'(guess_valid), 0);
    run(tbl[0], 8);

`ifdef GUESS_TIMEOUT_EN
    begin
      int cyc;
      secret = 4'd9; mode = 0; comp_valid = 1'b0;
      start = 1'b1; step(); start = 1'b0;
      cyc = 1;
      while (!err && cyc < 50) begin step(); cyc++; end
      check("tmo err", int'(err), 1);
      check("tmo cycle", cyc, 6);
      check("tmo steps", int'(steps), 0);
      check("tmo done", int'(done), 0);
      comp_valid = 1'b1;
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
